// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t : host-transaction sequencing states
//     IDLE   - no host transaction in flight; the host may be granted this cycle
//     H_DATA - cycle after the host grant; RAM read data for the host is valid
//     H_ACK  - completion pulse cycle; host_req is ignored
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    H_DATA = 2'd1,
    H_ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port synchronous data RAM between the CPU
// (pipeline stage 2) and a host/debug port. The CPU has priority, but a
// pending host request is forced through after MAX_WAIT lost cycles. The
// CPU is stalled in any cycle where the host is granted and the CPU also
// wants the memory.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   cpu_req/addr/we/wdata   CPU access request for this cycle
//   cpu_stall               CPU access not performed; pipeline holds
//   cpu_rdata               RAM read data (valid the cycle after an unstalled read)
//   host_req/we/addr/wdata  host request, held until host_ack
//   host_ack                one-cycle completion pulse
//   host_rdata              registered host read data
//   mem_addr/we/wdata       RAM command
//   mem_rdata               RAM read data, one-cycle latency
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic                 cpu_we,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_stall,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_ack,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  arb_state_t           state, state_next;
  logic [CNT_W-1:0]     wait_cnt, wait_next;
  logic                 host_read, host_read_next;
  logic                 ack_next;
  logic [WORD_SIZE-1:0] rdata_next;
  logic                 host_go;

  // Host wins when the CPU is idle or the host has already lost MAX_WAIT cycles.
  assign host_go = (state == IDLE) && host_req && (!cpu_req || (wait_cnt == WAIT_LIMIT));

  // RAM read data goes straight to the CPU; it only consumes it after an unstalled access.
  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_we && cpu_req;
    cpu_stall = 1'b0;
    if (host_go) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
      cpu_stall = cpu_req;
    end
    // No RAM write may slip through while the system is held in reset.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_comb begin
    state_next     = state;
    wait_next      = wait_cnt;
    host_read_next = host_read;
    ack_next       = 1'b0;
    rdata_next     = host_rdata;
    case (state)
      IDLE: begin
        if (host_go) begin
          state_next     = H_DATA;
          wait_next      = '0;
          host_read_next = !host_we;
        end else if (host_req) begin
          // Here the CPU took the cycle; count the loss, saturating.
          if (wait_cnt != WAIT_LIMIT) begin
            wait_next = wait_cnt + CNT_W'(1);
          end
        end else begin
          // Request absent (or withdrawn before grant): start the bound over.
          wait_next = '0;
        end
      end
      H_DATA: begin
        if (host_read) begin
          rdata_next = mem_rdata;
        end
        ack_next   = 1'b1;
        state_next = H_ACK;
      end
      H_ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      host_read  <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      host_read  <= host_read_next;
      host_ack   <= ack_next;
      host_rdata <= rdata_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [17:0] cpu_addr;
  logic        cpu_we;
  logic [17:0] cpu_wdata;
  logic        cpu_stall;
  logic [17:0] cpu_rdata;
  logic        host_req;
  logic        host_we;
  logic [17:0] host_addr;
  logic [17:0] host_wdata;
  logic        host_ack;
  logic [17:0] host_rdata;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [17:0] mem_wdata;
  logic [17:0] mem_rdata;

  logic [17:0] ram [0:262143];

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.ADDR_SIZE(18), .WORD_SIZE(18), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Single-port synchronous RAM, read-before-write, one-cycle read latency.
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle: inputs change just after the falling edge.
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic host_set(input logic req, input logic we, input logic [17:0] a, input logic [17:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [17:0] a, input logic [17:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = '0;
    ram[18'h00010] = 18'h2ABCD;
    ram[18'h00030] = 18'h11111;
    mem_rdata = '0;

    // Reset, with a CPU write presented to prove it is gated
    reset = 1'b1;
    host_set(0, 0, 0, 0);
    cpu_set(1, 1, 18'h00050, 18'h00777);
    cyc();
    cyc(); #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_stall", cpu_stall, 0);

    // Idle CPU host read of 0x10
    cyc(); reset = 1'b0;
    cpu_set(0, 0, 0, 0);
    host_set(1, 0, 18'h00010, 0); #1;
    chk("t1_grant_addr", mem_addr, 18'h00010);
    chk("t1_grant_we", mem_we, 0);
    chk("t1_grant_stall", cpu_stall, 0);
    // H_DATA: concurrent CPU read of 0x30
    cyc(); cpu_set(1, 0, 18'h00030, 0); #1;
    chk("t1_hdata_ack", host_ack, 0);
    chk("t1_hdata_addr", mem_addr, 18'h00030);
    chk("t1_hdata_stall", cpu_stall, 0);
    // H_ACK
    cyc(); cpu_set(0, 0, 0, 0); #1;
    chk("t1_ack", host_ack, 1);
    chk("t1_rdata", host_rdata, 18'h2ABCD);
    chk("t1_cpu_rdata", cpu_rdata, 18'h11111);
    chk("t1_hack_stall", cpu_stall, 0);
    cyc(); host_set(0, 0, 0, 0); #1;
    chk("t1_ack_drop", host_ack, 0);
    chk("t1_rdata_hold", host_rdata, 18'h2ABCD);

    // CPU priority: host write 0x20 <= 0x123 with cpu_req held
    cpu_set(1, 0, 18'h00040, 0);
    for (int p = 1; p <= 5; p++) begin
      cyc(); host_set(1, 1, 18'h00020, 18'h00123); #1;
      chk($sformatf("t2_stall_p%0d", p), cpu_stall, (p == 5));
      chk($sformatf("t2_addr_p%0d", p), mem_addr, (p == 5) ? 18'h00020 : 18'h00040);
      chk($sformatf("t2_we_p%0d", p), mem_we, (p == 5));
    end
    cyc(); #1;
    chk("t2_hdata_ack", host_ack, 0);
    chk("t2_hdata_stall", cpu_stall, 0);
    cyc(); cpu_set(0, 0, 0, 0); #1;
    chk("t2_ack", host_ack, 1);
    chk("t2_rdata_unchanged", host_rdata, 18'h2ABCD);
    chk("t2_ram", ram[18'h00020], 18'h00123);
    cyc(); host_set(0, 0, 0, 0); #1;
    chk("t2_ack_drop", host_ack, 0);

    // Back-to-back: host_req held through host_ack
    cyc(); cpu_set(0, 0, 18'h00055, 0); host_set(1, 0, 18'h00030, 0); #1;
    chk("t3_g1_addr", mem_addr, 18'h00030);
    cyc(); #1;
    chk("t3_hdata1_ack", host_ack, 0);
    cyc(); #1;
    chk("t3_ack1", host_ack, 1);
    chk("t3_rdata1", host_rdata, 18'h11111);
    chk("t3_hack_no_grant", mem_addr, 18'h00055);
    cyc(); host_set(1, 0, 18'h00010, 0); #1;
    chk("t3_g2_addr", mem_addr, 18'h00010);
    chk("t3_g2_ack", host_ack, 0);
    cyc(); #1;
    chk("t3_hdata2_ack", host_ack, 0);
    cyc(); #1;
    chk("t3_ack2", host_ack, 1);
    chk("t3_rdata2", host_rdata, 18'h2ABCD);
    cyc(); host_set(0, 0, 0, 0); #1;
    chk("t3_ack2_drop", host_ack, 0);

    // Reset during H_DATA after a host read grant
    cyc(); host_set(1, 0, 18'h00030, 0); #1;
    chk("t4_grant_addr", mem_addr, 18'h00030);
    cyc(); reset = 1'b1; cpu_set(1, 1, 18'h00060, 18'h00999); #1;
    chk("t4_rst_mem_we", mem_we, 0);
    cyc(); reset = 1'b0; cpu_set(0, 0, 0, 0); host_set(0, 0, 0, 0); #1;
    chk("t4_no_ack", host_ack, 0);
    chk("t4_rdata_clr", host_rdata, 0);
    chk("t4_ram60", ram[18'h00060], 0);
    cyc(); #1;
    chk("t4_no_ack2", host_ack, 0);

    // Host write 0x3FFFF to 0x3FFFF, then read it back
    cyc(); host_set(1, 1, 18'h3FFFF, 18'h3FFFF); #1;
    chk("t5_w_addr", mem_addr, 18'h3FFFF);
    chk("t5_w_we", mem_we, 1);
    chk("t5_w_data", mem_wdata, 18'h3FFFF);
    cyc(); cyc(); #1;
    chk("t5_w_ack", host_ack, 1);
    chk("t5_w_rdata", host_rdata, 0);
    cyc(); host_set(0, 0, 0, 0);
    cyc(); host_set(1, 0, 18'h3FFFF, 0); #1;
    chk("t5_r_addr", mem_addr, 18'h3FFFF);
    cyc(); cyc(); #1;
    chk("t5_r_ack", host_ack, 1);
    chk("t5_r_rdata", host_rdata, 18'h3FFFF);
    cyc(); host_set(0, 0, 0, 0);

    // Request withdrawn before grant restarts the wait bound
    cpu_set(1, 0, 18'h00040, 0);
    for (int p = 1; p <= 3; p++) begin
      cyc(); host_set(1, 0, 18'h00020, 0); #1;
      chk($sformatf("t6_pre_stall_p%0d", p), cpu_stall, 0);
    end
    cyc(); host_set(0, 0, 0, 0); #1;
    chk("t6_drop_stall", cpu_stall, 0);
    for (int p = 1; p <= 5; p++) begin
      cyc(); host_set(1, 0, 18'h00020, 0); #1;
      chk($sformatf("t6_stall_p%0d", p), cpu_stall, (p == 5));
    end
    cyc(); cpu_set(0, 0, 0, 0);
    cyc(); #1;
    chk("t6_ack", host_ack, 1);
    chk("t6_rdata", host_rdata, 18'h00123);
    cyc(); host_set(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
